// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
//   Shared definitions for the shift-and-add multiplier.
//   - state_t    : controller states (IDLE, RUN, DONE)
//   - cnt_width(): bit width of an iteration counter that must count 0..W
// -----------------------------------------------------------------------------
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter able to hold the value w (iteration counts 0..w).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : mul_pkg

// File: rtl/mag_conv.sv
// -----------------------------------------------------------------------------
// mag_conv
//   Combinational sign/magnitude conditioning, width N.
//   The value is negated (two's complement, N bits) when it is a negative
//   signed number (sgn=1 and MSB set), XOR-ed with an explicit flip request.
//   Operand conditioning uses flip=0; the final result negation uses sgn=0
//   and drives flip with the recorded result sign.
//
//   Ports:
//     value [N-1:0] in  : input value
//     sgn           in  : 1 = treat value as two's complement
//     flip          in  : force an extra negation
//     mag   [N-1:0] out : conditioned value (magnitude for operands)
//     sign          out : 1 when mag is the negation of value
// -----------------------------------------------------------------------------
module mag_conv #(
    parameter int N = 4
) (
    input  logic [N-1:0] value,
    input  logic         sgn,
    input  logic         flip,
    output logic [N-1:0] mag,
    output logic         sign
);

    logic negate;

    assign negate = (sgn & value[N-1]) ^ flip;
    // -2^(N-1) maps onto itself, which read unsigned is exactly 2^(N-1).
    // Negating zero yields zero, so a zero product stays zero.
    assign mag    = negate ? (~value + N'(1)) : value;
    assign sign   = negate;

endmodule : mag_conv

// File: rtl/shift_add_mul.sv
// -----------------------------------------------------------------------------
// shift_add_mul
//   Sequential W x W -> 2W multiplier, unsigned or two's complement per
//   operation. Operands are captured on start; the product is formed by
//   shift-and-add over W RUN cycles, then presented with a one-cycle done.
//
//   Handshake: start is only looked at in IDLE or DONE. An accepted start
//   captures a, b and sgn; nothing else about the inputs matters afterwards.
//   busy is high exactly in the W RUN cycles; done is high for the single
//   cycle following RUN, and z holds its value from that cycle until the next
//   done (or reset). Holding start high in DONE chains operations
//   back-to-back, one result every W+1 cycles.
//
//   Ports:
//     clk             in  : clock, rising edge
//     rst_n           in  : synchronous active-low reset
//     start           in  : request strobe
//     sgn             in  : 1 = two's-complement operands
//     a, b    [W-1:0] in  : multiplicand, multiplier
//     z     [2W-1:0]  out : registered product
//     busy            out : operation in progress (RUN)
//     done            out : one-cycle pulse when z updates
//     dbg_state [1:0] out : current controller state (state_t encoding)
// -----------------------------------------------------------------------------
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   z,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int CW = cnt_width(W);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [2*W-1:0]    mcand_q;
    logic [W-1:0]      mplier_q;
    logic [2*W-1:0]    acc_q;
    logic              neg_q;
    logic [2*W-1:0]    z_q;

    logic              accept;
    logic              last;
    logic [2*W-1:0]    acc_sum;

    logic [W-1:0]      a_mag, b_mag;
    logic              a_sign, b_sign;
    logic [2*W-1:0]    z_conv;
    logic              z_negated;

    // Operand conditioning: magnitudes plus per-operand sign.
    mag_conv #(.N(W)) u_mag_a (
        .value (a),
        .sgn   (sgn),
        .flip  (1'b0),
        .mag   (a_mag),
        .sign  (a_sign)
    );

    mag_conv #(.N(W)) u_mag_b (
        .value (b),
        .sgn   (sgn),
        .flip  (1'b0),
        .mag   (b_mag),
        .sign  (b_sign)
    );

    // Final conditional negation of the completed accumulator. neg_q is only
    // ever set for signed operations, so unsigned results pass straight through.
    mag_conv #(.N(2 * W)) u_neg_z (
        .value (acc_sum),
        .sgn   (1'b0),
        .flip  (neg_q),
        .mag   (z_conv),
        .sign  (z_negated)
    );

    // Accumulator value after this cycle's conditional add.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(W - 1)) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            z_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q    <= '0;
                mcand_q  <= {{W{1'b0}}, a_mag};
                mplier_q <= b_mag;
                acc_q    <= '0;
                neg_q    <= a_sign ^ b_sign;
            end else if (state_q == RUN) begin
                cnt_q    <= cnt_q + CW'(1);
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                acc_q    <= acc_sum;
                if (last) begin
                    z_q <= z_negated ? z_conv : acc_sum;
                end
            end
        end
    end

    assign z         = z_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule : shift_add_mul

// File: tb/tb_shift_add_mul.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mul
//   Directed bench for shift_add_mul with a W=4 and a W=8 instance sharing
//   clock and reset. Inputs change on the falling edge, outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_shift_add_mul;
    import mul_pkg::*;

    logic        clk;
    logic        rst_n;

    logic        start4, sgn4;
    logic [3:0]  a4, b4;
    logic [7:0]  z4;
    logic        busy4, done4;
    logic [1:0]  st4;

    logic        start8, sgn8;
    logic [7:0]  a8, b8;
    logic [15:0] z8;
    logic        busy8, done8;
    logic [1:0]  st8;

    int n_cmp;
    int n_fail;

    shift_add_mul #(.W(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start4),
        .sgn       (sgn4),
        .a         (a4),
        .b         (b4),
        .z         (z4),
        .busy      (busy4),
        .done      (done4),
        .dbg_state (st4)
    );

    shift_add_mul #(.W(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start8),
        .sgn       (sgn8),
        .a         (a8),
        .b         (b8),
        .z         (z8),
        .busy      (busy8),
        .done      (done8),
        .dbg_state (st8)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: one W=4 operation; operands are scrambled right after acceptance.
    task automatic run4(input logic [3:0] ia, input logic [3:0] ib, input logic isgn,
                        output logic [7:0] oz, output int lat);
        @(negedge clk);
        a4 = ia; b4 = ib; sgn4 = isgn; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom_range(0, 15));
        b4 = 4'($urandom_range(0, 15));
        sgn4 = ~isgn;
        lat = 1;
        while (done4 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        oz = z4;
    endtask

    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic isgn,
                        output logic [15:0] oz, output int lat);
        @(negedge clk);
        a8 = ia; b8 = ib; sgn8 = isgn; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        sgn8 = ~isgn;
        lat = 1;
        while (done8 !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        oz = z8;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start4 = 1'b1; sgn4 = 1'b0; a4 = 4'hF; b4 = 4'hF;
        start8 = 1'b1; sgn8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (z4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0 || st4 !== 2'(IDLE)) begin
            n_fail++;
            $display("FAIL reset4: z=%h busy=%b done=%b st=%0d, required z=00 busy=0 done=0 st=0",
                     z4, busy4, done4, st4);
        end
        n_cmp++;
        if (z8 !== 16'h0000 || busy8 !== 1'b0 || done8 !== 1'b0 || st8 !== 2'(IDLE)) begin
            n_fail++;
            $display("FAIL reset8: z=%h busy=%b done=%b st=%0d, required z=0000 busy=0 done=0 st=0",
                     z8, busy8, done8, st8);
        end
        // start was high throughout reset: it must have been dropped.
        rst_n = 1'b1;
        start4 = 1'b0;
        start8 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy4 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_dropped: busy4=%b busy8=%b, required 0 0", busy4, busy8);
        end
    endtask

    task automatic test_unsigned_sweep();
        logic [7:0] got;
        logic [7:0] exp;
        int lat;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run4(4'(i), 4'(j), 1'b0, got, lat);
                exp = 8'(i * j);
                n_cmp++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL unsigned %0d*%0d: z=%h required %h", i, j, got, exp);
                end
                n_cmp++;
                if (lat != 5) begin
                    n_fail++;
                    $display("FAIL unsigned_latency %0d*%0d: %0d cycles required 5", i, j, lat);
                end
            end
        end
    endtask

    task automatic test_signed_corners();
        logic [3:0] ta [5] = '{4'h8, 4'h8, 4'hF, 4'h0, 4'hF};
        logic [3:0] tb [5] = '{4'h8, 4'h7, 4'h1, 4'hB, 4'h1};
        logic       ts [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] tz [5] = '{8'h40, 8'hC8, 8'hFF, 8'h00, 8'h0F};
        logic [7:0] got;
        int lat;
        for (int k = 0; k < 5; k++) begin
            run4(ta[k], tb[k], ts[k], got, lat);
            n_cmp++;
            if (got !== tz[k] || lat != 5) begin
                n_fail++;
                $display("FAIL signed_corner[%0d] a=%h b=%h sgn=%b: z=%h lat=%0d required z=%h lat=5",
                         k, ta[k], tb[k], ts[k], got, lat, tz[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd5; sgn4 = 1'b0; start4 = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            exp_done = (k % 5 == 0);
            n_cmp++;
            if (done4 !== exp_done || busy4 !== !exp_done) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: done=%b busy=%b required done=%b busy=%b",
                         k, done4, busy4, exp_done, !exp_done);
            end
            if (exp_done) begin
                n_cmp++;
                if (z4 !== 8'h0F) begin
                    n_fail++;
                    $display("FAIL back_to_back_z cycle %0d: z=%h required 0f", k, z4);
                end
            end
        end
        start4 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int n_done;
        int first_done;
        logic [7:0] z_at_done;
        n_done = 0;
        first_done = -1;
        z_at_done = 8'h00;
        @(negedge clk);
        a4 = 4'd6; b4 = 4'd7; sgn4 = 1'b0; start4 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start4 = (k == 2);
            if (k == 2) begin
                a4 = 4'hF; b4 = 4'hF;
            end
            if (done4 === 1'b1) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = k;
                    z_at_done = z4;
                end
            end
        end
        n_cmp++;
        if (n_done != 1 || first_done != 5) begin
            n_fail++;
            $display("FAIL start_ignored_done: %0d pulses first at %0d, required 1 at 5",
                     n_done, first_done);
        end
        n_cmp++;
        if (z_at_done !== 8'h2A) begin
            n_fail++;
            $display("FAIL start_ignored_z: z=%h required 2a", z_at_done);
        end
        n_cmp++;
        if (z4 !== 8'h2A || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored_hold: z=%h busy=%b required z=2a busy=0", z4, busy4);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_done;
        logic [7:0] got;
        int lat;
        n_done = 0;
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd3; sgn4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (z4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0 || st4 !== 2'(IDLE)) begin
            n_fail++;
            $display("FAIL reset_mid_run: z=%h busy=%b done=%b st=%0d, required z=00 busy=0 done=0 st=0",
                     z4, busy4, done4, st4);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done4 === 1'b1) n_done++;
        end
        n_cmp++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL reset_mid_run_no_done: %0d pulses required 0", n_done);
        end
        run4(4'd9, 4'd9, 1'b0, got, lat);
        n_cmp++;
        if (got !== 8'h51 || lat != 5) begin
            n_fail++;
            $display("FAIL reset_mid_run_restart: z=%h lat=%0d required z=51 lat=5", got, lat);
        end
    endtask

    task automatic test_width8();
        logic [15:0] got;
        int lat;
        run8(8'hFF, 8'hFF, 1'b0, got, lat);
        n_cmp++;
        if (got !== 16'hFE01 || lat != 9) begin
            n_fail++;
            $display("FAIL width8_unsigned: z=%h lat=%0d required z=fe01 lat=9", got, lat);
        end
        run8(8'h80, 8'h80, 1'b1, got, lat);
        n_cmp++;
        if (got !== 16'h4000 || lat != 9) begin
            n_fail++;
            $display("FAIL width8_min_sq: z=%h lat=%0d required z=4000 lat=9", got, lat);
        end
        run8(8'hFD, 8'h05, 1'b1, got, lat);
        n_cmp++;
        if (got !== 16'hFFF1 || lat != 9) begin
            n_fail++;
            $display("FAIL width8_neg: z=%h lat=%0d required z=fff1 lat=9", got, lat);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_unsigned_sweep();
        test_signed_corners();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_run();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_shift_add_mul
